// File: rtl/sprite_line_engine.sv
`default_nettype none
// ============================================================================
// Module   : sprite_line_engine
// Purpose  : Per-scanline sprite engine. While one line is displayed, the
//            configs of all sprites are scanned for the next line and their
//            pattern rows are prefetched into the "next" slot bank. At each
//            line_start the banks swap. A registered per-pixel hit and RGB
//            come out of the "current" bank for mixing over the tile layer.
// Ports    : clk, resetn          clock, synchronous active-low reset
//            iomem_*              32-bit register bus, one-cycle ready pulse
//                                 words 0..N-1 sprite config, 32 COLLISION,
//                                 33 STATUS
//            line_start, line_y   start of hblank, line to evaluate next
//            pix_valid, pix_x     active pixel strobe and column
//            mem_ren/raddr/rdata  pattern row fetch, 1-cycle read latency
//            sprite_hit/rgb       registered pixel result, {B,G,R}
// Revision : 1.0  initial release
// ============================================================================
module sprite_line_engine #(
  parameter int NUM_SPRITES  = 16,
  parameter int MAX_PER_LINE = 4,
  parameter int PATTERN_BITS = 6
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    iomem_valid,
  input  logic [3:0]              iomem_wstrb,
  input  logic [7:0]              iomem_addr,
  input  logic [31:0]             iomem_wdata,
  output logic [31:0]             iomem_rdata,
  output logic                    iomem_ready,
  input  logic                    line_start,
  input  logic [8:0]              line_y,
  input  logic                    pix_valid,
  input  logic [8:0]              pix_x,
  output logic                    mem_ren,
  output logic [PATTERN_BITS+3:0] mem_raddr,
  input  logic [15:0]             mem_rdata,
  output logic                    sprite_hit,
  output logic [2:0]              sprite_rgb
);

  localparam logic [4:0]  c_last_idx  = 5'(NUM_SPRITES - 1);
  localparam logic [5:0]  c_num_words = 6'(NUM_SPRITES);
  localparam logic [3:0]  c_max_slots = 4'(MAX_PER_LINE);
  // Bits 30:29 of a config word have no function and always read back 0.
  localparam logic [31:0] c_cfg_mask  = 32'h9FFF_FFFF;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SCAN   = 2'd1,
    ST_FINISH = 2'd2
  } state_t;

  typedef struct packed {
    logic        valid;
    logic [15:0] row;
    logic [8:0]  x;
    logic        hflip;
    logic [2:0]  rgb;
    logic [4:0]  idx;
  } slot_t;

  // Storage is sized for the maximum legal parameters; entries beyond
  // NUM_SPRITES / MAX_PER_LINE are never written and stay at reset value.
  logic [31:0] cfg_q  [0:31];
  logic [31:0] cfg_d  [0:31];
  slot_t       cur_q  [0:7];
  slot_t       cur_d  [0:7];
  slot_t       nxt_q  [0:7];
  slot_t       nxt_d  [0:7];
  state_t      state_q, state_d;
  logic [4:0]  idx_q, idx_d;
  logic [8:0]  y_q, y_d;
  logic [3:0]  alloc_q, alloc_d;
  logic [3:0]  used_q, used_d;
  logic        pend_q, pend_d;
  logic [2:0]  pend_slot_q, pend_slot_d;
  slot_t       pend_info_q, pend_info_d;
  logic [31:0] coll_q, coll_d;
  logic        ovf_q, ovf_d;
  logic        ready_q, ready_d;
  logic [31:0] rdata_q, rdata_d;
  logic        hit_q, hit_d;
  logic [2:0]  rgb_q, rgb_d;

  logic [31:0] w_cfg;
  logic [8:0]  w_dy;
  logic [3:0]  w_row;
  logic        w_vis, w_issue, w_ovf_set;
  slot_t       w_nxt_merged [0:7];
  logic        w_pix_any;
  logic [2:0]  w_pix_rgb;
  logic [31:0] w_coll_set;
  logic        w_acc, w_wr, w_rd;
  logic [5:0]  w_word;

  // ---------------------------------------------------------------- scan
  always_comb begin
    w_cfg     = cfg_q[idx_q];
    w_dy      = y_q - w_cfg[17:9];
    w_vis     = w_cfg[31] && (w_dy[8:4] == 5'd0);
    w_issue   = (state_q == ST_SCAN) && w_vis && (alloc_q < c_max_slots);
    w_ovf_set = (state_q == ST_SCAN) && w_vis && !(alloc_q < c_max_slots);
    w_row     = w_cfg[25] ? ~w_dy[3:0] : w_dy[3:0];

    // Next bank as it looks once the outstanding row fetch lands; used both
    // for the normal capture and when a line_start swaps a partial scan in.
    w_nxt_merged = nxt_q;
    if (pend_q) begin
      w_nxt_merged[pend_slot_q]       = pend_info_q;
      w_nxt_merged[pend_slot_q].row   = mem_rdata;
      w_nxt_merged[pend_slot_q].valid = 1'b1;
    end

    state_d     = state_q;
    idx_d       = idx_q;
    y_d         = y_q;
    alloc_d     = alloc_q;
    used_d      = used_q;
    pend_d      = 1'b0;
    pend_slot_d = pend_slot_q;
    pend_info_d = pend_info_q;
    cur_d       = cur_q;
    nxt_d       = w_nxt_merged;

    case (state_q)
      ST_SCAN: begin
        if (w_issue) begin
          pend_d            = 1'b1;
          pend_slot_d       = alloc_q[2:0];
          pend_info_d       = '0;
          pend_info_d.x     = w_cfg[8:0];
          pend_info_d.hflip = w_cfg[24];
          pend_info_d.rgb   = w_cfg[28:26];
          pend_info_d.idx   = idx_q;
          alloc_d           = alloc_q + 4'd1;
        end
        if (idx_q == c_last_idx) state_d = ST_FINISH;
        else                     idx_d   = idx_q + 5'd1;
      end
      ST_FINISH: begin
        // Final fetch is captured this cycle; alloc_q already counts it.
        used_d  = alloc_q;
        state_d = ST_IDLE;
      end
      default: ;
    endcase

    if (line_start) begin
      cur_d = w_nxt_merged;
      for (int s = 0; s < 8; s++) nxt_d[s] = '0;
      alloc_d = 4'd0;
      idx_d   = 5'd0;
      y_d     = line_y;
      pend_d  = 1'b0;
      state_d = ST_SCAN;
    end
  end

  assign mem_ren   = w_issue;
  assign mem_raddr = {w_cfg[18 +: PATTERN_BITS], w_row};

  // --------------------------------------------------------------- pixel
  always_comb begin
    logic [8:0] col;
    logic       opaque;
    logic [3:0] n_opaque;
    logic [31:0] mask;
    w_pix_any = 1'b0;
    w_pix_rgb = 3'd0;
    n_opaque  = 4'd0;
    mask      = '0;
    col       = '0;
    opaque    = 1'b0;
    // Descending walk so the lowest-index opaque slot is the last writer.
    for (int s = MAX_PER_LINE - 1; s >= 0; s--) begin
      col    = pix_x - cur_q[s].x;
      opaque = cur_q[s].valid && (col[8:4] == 5'd0) &&
               (cur_q[s].hflip ? cur_q[s].row[col[3:0]]
                               : cur_q[s].row[4'd15 - col[3:0]]);
      if (opaque) begin
        w_pix_any = 1'b1;
        w_pix_rgb = cur_q[s].rgb;
        n_opaque  = n_opaque + 4'd1;
        mask      = mask | (32'd1 << cur_q[s].idx);
      end
    end
    w_coll_set = (pix_valid && (n_opaque >= 4'd2)) ? mask : 32'd0;
    hit_d      = pix_valid && w_pix_any;
    rgb_d      = (pix_valid && w_pix_any) ? w_pix_rgb : 3'd0;
  end

  // ----------------------------------------------------------------- bus
  always_comb begin
    w_acc   = iomem_valid && !ready_q;
    w_word  = iomem_addr[7:2];
    w_wr    = w_acc && (iomem_wstrb != 4'd0);
    w_rd    = w_acc && (iomem_wstrb == 4'd0);
    ready_d = w_acc;
    rdata_d = 32'd0;
    cfg_d   = cfg_q;
    coll_d  = coll_q;
    ovf_d   = ovf_q;

    if (w_rd) begin
      if (w_word < c_num_words) begin
        rdata_d = cfg_q[w_word[4:0]];
      end else if (w_word == 6'd32) begin
        rdata_d = coll_q;
        coll_d  = 32'd0;
      end else if (w_word == 6'd33) begin
        rdata_d = {20'd0, used_q, 7'd0, ovf_q};
        ovf_d   = 1'b0;
      end
    end

    if (w_wr && (w_word < c_num_words)) begin
      for (int b = 0; b < 4; b++) begin
        if (iomem_wstrb[b]) cfg_d[w_word[4:0]][8*b +: 8] = iomem_wdata[8*b +: 8];
      end
      cfg_d[w_word[4:0]] = cfg_d[w_word[4:0]] & c_cfg_mask;
    end

    // Applied after the read-clear so a same-cycle set survives.
    coll_d = coll_d | w_coll_set;
    ovf_d  = ovf_d | w_ovf_set;
  end

  // --------------------------------------------------------------- state
  always_ff @(posedge clk) begin
    if (!resetn) begin
      for (int i = 0; i < 32; i++) cfg_q[i] <= '0;
      for (int s = 0; s < 8; s++) begin
        cur_q[s] <= '0;
        nxt_q[s] <= '0;
      end
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      y_q         <= '0;
      alloc_q     <= '0;
      used_q      <= '0;
      pend_q      <= 1'b0;
      pend_slot_q <= '0;
      pend_info_q <= '0;
      coll_q      <= '0;
      ovf_q       <= 1'b0;
      ready_q     <= 1'b0;
      rdata_q     <= '0;
      hit_q       <= 1'b0;
      rgb_q       <= '0;
    end else begin
      cfg_q       <= cfg_d;
      cur_q       <= cur_d;
      nxt_q       <= nxt_d;
      state_q     <= state_d;
      idx_q       <= idx_d;
      y_q         <= y_d;
      alloc_q     <= alloc_d;
      used_q      <= used_d;
      pend_q      <= pend_d;
      pend_slot_q <= pend_slot_d;
      pend_info_q <= pend_info_d;
      coll_q      <= coll_d;
      ovf_q       <= ovf_d;
      ready_q     <= ready_d;
      rdata_q     <= rdata_d;
      hit_q       <= hit_d;
      rgb_q       <= rgb_d;
    end
  end

  assign iomem_ready = ready_q;
  assign iomem_rdata = rdata_q;
  assign sprite_hit  = hit_q;
  assign sprite_rgb  = rgb_q;

  logic unused_bits;
  assign unused_bits = &{1'b0, iomem_addr[1:0], w_cfg[30:29]};

endmodule
`default_nettype wire

// File: tb/tb_sprite_line_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_sprite_line_engine
// Purpose  : Scoreboard bench for sprite_line_engine. Stimulus pushes the
//            expected bus read data and pixel results into queues; a monitor
//            pops and compares whenever iomem_ready or a delayed pix_valid
//            says the DUT is presenting a result.
// Revision : 1.0  initial release
// ============================================================================
module tb_sprite_line_engine;

  localparam int NUM_SPRITES  = 16;
  localparam int MAX_PER_LINE = 4;
  localparam int PATTERN_BITS = 6;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        iomem_valid = 1'b0;
  logic [3:0]  iomem_wstrb = 4'd0;
  logic [7:0]  iomem_addr = 8'd0;
  logic [31:0] iomem_wdata = 32'd0;
  logic [31:0] iomem_rdata;
  logic        iomem_ready;
  logic        line_start = 1'b0;
  logic [8:0]  line_y = 9'd0;
  logic        pix_valid = 1'b0;
  logic [8:0]  pix_x = 9'd0;
  logic        mem_ren;
  logic [PATTERN_BITS+3:0] mem_raddr;
  logic [15:0] mem_rdata = 16'd0;
  logic        sprite_hit;
  logic [2:0]  sprite_rgb;

  always #5 clk = ~clk;

  sprite_line_engine #(
    .NUM_SPRITES (NUM_SPRITES),
    .MAX_PER_LINE(MAX_PER_LINE),
    .PATTERN_BITS(PATTERN_BITS)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .iomem_valid(iomem_valid),
    .iomem_wstrb(iomem_wstrb),
    .iomem_addr (iomem_addr),
    .iomem_wdata(iomem_wdata),
    .iomem_rdata(iomem_rdata),
    .iomem_ready(iomem_ready),
    .line_start (line_start),
    .line_y     (line_y),
    .pix_valid  (pix_valid),
    .pix_x      (pix_x),
    .mem_ren    (mem_ren),
    .mem_raddr  (mem_raddr),
    .mem_rdata  (mem_rdata),
    .sprite_hit (sprite_hit),
    .sprite_rgb (sprite_rgb)
  );

  // Pattern memory model with one cycle of read latency.
  logic [15:0] pmem [0:1023];
  logic [9:0]  raddr_log [$];
  always @(posedge clk) begin
    if (mem_ren) begin
      mem_rdata <= pmem[mem_raddr];
      raddr_log.push_back(mem_raddr);
    end
  end

  typedef struct { bit chk; logic [31:0] val; string name; } bus_exp_t;
  typedef struct { logic hit; logic [2:0] rgb; string name; } pix_exp_t;
  bus_exp_t bus_q [$];
  pix_exp_t pix_q [$];
  int checks = 0;
  int errors = 0;

  logic pv_d = 1'b0;
  always @(posedge clk) pv_d <= pix_valid;

  // Monitor: results are registered, so sample on the falling edge.
  always @(negedge clk) begin
    bus_exp_t be;
    pix_exp_t pe;
    if (iomem_ready) begin
      if (bus_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL bus_unexpected_ready: rdata=0x%0h with nothing outstanding", iomem_rdata);
      end else begin
        be = bus_q.pop_front();
        if (be.chk) begin
          checks++;
          if (iomem_rdata !== be.val) begin
            errors++;
            $display("FAIL %s: rdata=0x%0h expected 0x%0h", be.name, iomem_rdata, be.val);
          end
        end
      end
    end
    if (pv_d) begin
      if (pix_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL pix_unexpected: no expectation queued");
      end else begin
        pe = pix_q.pop_front();
        checks++;
        if (sprite_hit !== pe.hit || sprite_rgb !== pe.rgb) begin
          errors++;
          $display("FAIL %s: hit=%b rgb=%b expected hit=%b rgb=%b",
                   pe.name, sprite_hit, sprite_rgb, pe.hit, pe.rgb);
        end
      end
    end else begin
      checks++;
      if (sprite_hit !== 1'b0 || sprite_rgb !== 3'd0) begin
        errors++;
        $display("FAIL pix_idle: hit=%b rgb=%b expected hit=0 rgb=000", sprite_hit, sprite_rgb);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_access(input logic [5:0] word, input logic [3:0] strb, input logic [31:0] wd,
                            input bit chk_en, input logic [31:0] exp, input string name);
    bus_exp_t e;
    bit got;
    e.chk = chk_en; e.val = exp; e.name = name;
    bus_q.push_back(e);
    iomem_valid = 1'b1; iomem_addr = {word, 2'b00}; iomem_wstrb = strb; iomem_wdata = wd;
    got = 1'b0;
    for (int i = 0; i < 8 && !got; i++) begin
      @(posedge clk); #1;
      if (iomem_ready) got = 1'b1;
    end
    iomem_valid = 1'b0; iomem_wstrb = 4'd0;
    if (!got) begin
      checks++; errors++;
      $display("FAIL %s_timeout: iomem_ready=0 expected 1 within 8 cycles", name);
    end
    cyc(1);
  endtask

  task automatic wr(input logic [5:0] word, input logic [31:0] d);
    bus_access(word, 4'hF, d, 1'b0, 32'd0, "write");
  endtask

  task automatic rd(input logic [5:0] word, input logic [31:0] exp, input string name);
    bus_access(word, 4'h0, 32'd0, 1'b1, exp, name);
  endtask

  task automatic do_line(input logic [8:0] y);
    line_start = 1'b1; line_y = y;
    cyc(1);
    line_start = 1'b0;
    cyc(22);
  endtask

  task automatic pix(input logic [8:0] x, input logic h, input logic [2:0] rgb, input string name);
    pix_exp_t e;
    e.hit = h; e.rgb = rgb; e.name = name;
    pix_q.push_back(e);
    pix_valid = 1'b1; pix_x = x;
    cyc(1);
    pix_valid = 1'b0;
  endtask

  function automatic logic [31:0] mk(input logic [8:0] x, input logic [8:0] y, input logic [5:0] pat,
                                     input logic hf, input logic vf, input logic [2:0] rgb);
    return {1'b1, 2'b00, rgb, vf, hf, pat, y, x};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 1024; i++) pmem[i] = 16'h0000;
    for (int i = 16; i < 32; i++) pmem[i] = 16'hFFFF;   // pattern 1: solid
    pmem[32] = 16'h8000;                                // pattern 2 row 0
    pmem[47] = 16'h0001;                                // pattern 2 row 15

    // Reset state
    resetn = 1'b0;
    cyc(3);
    check("rst_ready", {31'd0, iomem_ready}, 32'd0);
    check("rst_rdata", iomem_rdata, 32'd0);
    check("rst_mem_ren", {31'd0, mem_ren}, 32'd0);
    check("rst_hit", {31'd0, sprite_hit}, 32'd0);
    check("rst_rgb", {29'd0, sprite_rgb}, 32'd0);
    resetn = 1'b1;
    cyc(1);
    rd(6'd32, 32'h0, "rst_collision");
    rd(6'd33, 32'h0, "rst_status");
    rd(6'd0,  32'h0, "rst_cfg0");

    // Register access: byte strobes, unused word
    wr(6'd7, 32'h1234_5678);
    bus_access(6'd7, 4'b0100, 32'h00AB_0000, 1'b0, 32'd0, "write_byte");
    rd(6'd7, 32'h12AB_5678, "cfg_byte_strobe");
    wr(6'd7, 32'd0);
    wr(6'd20, 32'hFFFF_FFFF);
    rd(6'd20, 32'h0, "unused_word");

    // Single sprite, x=100 y=50 red
    wr(6'd0, mk(9'd100, 9'd50, 6'd1, 1'b0, 1'b0, 3'b001));
    rd(6'd0, mk(9'd100, 9'd50, 6'd1, 1'b0, 1'b0, 3'b001), "cfg0_readback");
    do_line(9'd50);
    do_line(9'd300);
    pix(9'd99,  1'b0, 3'b000, "s0_x99");
    pix(9'd100, 1'b1, 3'b001, "s0_x100");
    pix(9'd115, 1'b1, 3'b001, "s0_x115");
    pix(9'd116, 1'b0, 3'b000, "s0_x116");
    cyc(2);

    // Collision: sprites 0 (R) and 3 (B) at x=200
    wr(6'd0, mk(9'd200, 9'd50, 6'd1, 1'b0, 1'b0, 3'b001));
    wr(6'd3, mk(9'd200, 9'd50, 6'd1, 1'b0, 1'b0, 3'b100));
    do_line(9'd50);
    do_line(9'd300);
    pix(9'd200, 1'b1, 3'b001, "coll_x200");
    cyc(2);
    rd(6'd32, 32'h9, "collision_set");
    rd(6'd32, 32'h0, "collision_cleared");

    // Overflow: 6 sprites on line 20, only 0..3 get slots
    for (int i = 0; i < 6; i++)
      wr(6'(i), mk(9'(10 + 20 * i), 9'd20, 6'd1, 1'b0, 1'b0, 3'((i % 7) + 1)));
    do_line(9'd20);
    rd(6'd33, 32'h401, "status_overflow");
    rd(6'd33, 32'h400, "status_ovf_cleared");
    do_line(9'd300);
    pix(9'd10, 1'b1, 3'd1, "ovf_s0");
    pix(9'd70, 1'b1, 3'd4, "ovf_s3");
    pix(9'd90, 1'b0, 3'd0, "ovf_s4_dropped");
    pix(9'd110, 1'b0, 3'd0, "ovf_s5_dropped");
    cyc(2);

    // hflip: row 0x8000 at x=40 shows only at 55
    for (int i = 0; i < 6; i++) wr(6'(i), 32'd0);
    wr(6'd2, mk(9'd40, 9'd100, 6'd2, 1'b1, 1'b0, 3'b010));
    do_line(9'd100);
    do_line(9'd300);
    pix(9'd40, 1'b0, 3'd0, "hflip_x40");
    pix(9'd54, 1'b0, 3'd0, "hflip_x54");
    pix(9'd55, 1'b1, 3'b010, "hflip_x55");
    pix(9'd56, 1'b0, 3'd0, "hflip_x56");
    cyc(2);

    // vflip: line 10 on sprite at y=10 fetches row 15
    wr(6'd2, mk(9'd40, 9'd10, 6'd2, 1'b0, 1'b1, 3'b010));
    raddr_log.delete();
    do_line(9'd10);
    check("vflip_fetch_count", 32'(raddr_log.size()), 32'd1);
    if (raddr_log.size() > 0) check("vflip_raddr", {22'd0, raddr_log[0]}, {22'd0, 6'd2, 4'd15});
    do_line(9'd300);
    pix(9'd40, 1'b0, 3'd0, "vflip_x40");
    pix(9'd55, 1'b1, 3'b010, "vflip_x55");
    cyc(2);

    // Horizontal wrap at x=505
    wr(6'd2, 32'd0);
    wr(6'd1, mk(9'd505, 9'd200, 6'd1, 1'b0, 1'b0, 3'b011));
    do_line(9'd200);
    do_line(9'd300);
    pix(9'd504, 1'b0, 3'd0, "wrap_x504");
    pix(9'd505, 1'b1, 3'b011, "wrap_x505");
    pix(9'd511, 1'b1, 3'b011, "wrap_x511");
    pix(9'd0,   1'b1, 3'b011, "wrap_x0");
    pix(9'd8,   1'b1, 3'b011, "wrap_x8");
    pix(9'd9,   1'b0, 3'd0, "wrap_x9");
    cyc(2);

    // Reset in the middle of a scan
    wr(6'd1, mk(9'd300, 9'd30, 6'd1, 1'b0, 1'b0, 3'b011));
    wr(6'd4, mk(9'd300, 9'd30, 6'd1, 1'b0, 1'b0, 3'b100));
    do_line(9'd30);
    do_line(9'd30);
    pix(9'd300, 1'b1, 3'b011, "pre_reset_x300");
    cyc(2);
    line_start = 1'b1; line_y = 9'd30;
    cyc(1);
    line_start = 1'b0;
    cyc(1);
    check("mid_scan_mem_ren", {31'd0, mem_ren}, 32'd1);
    resetn = 1'b0;
    cyc(1);
    check("reset_mem_ren", {31'd0, mem_ren}, 32'd0);
    check("reset_hit", {31'd0, sprite_hit}, 32'd0);
    resetn = 1'b1;
    cyc(1);
    rd(6'd32, 32'h0, "reset_collision");
    rd(6'd33, 32'h0, "reset_status");
    rd(6'd1,  32'h0, "reset_cfg1");

    cyc(5);
    check("bus_queue_empty", 32'(bus_q.size()), 32'd0);
    check("pix_queue_empty", 32'(pix_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
